// File: rtl/rv32i_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_fetch
//  Description : RV32I instruction-fetch front end. Single outstanding word
//                fetch over req/gnt/rvalid, one-entry decode buffer, redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    localparam logic [2:0]  c_st_idle  = 3'd0;
    localparam logic [2:0]  c_st_req   = 3'd1;
    localparam logic [2:0]  c_st_wait  = 3'd2;
    localparam logic [2:0]  c_st_full  = 3'd3;
    localparam logic [2:0]  c_st_drain = 3'd4;
    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic [31:0] w_redirect_pc;

    assign w_redirect_pc = next_pc & c_word_mask;

    // Redirect is tested first in every state so it wins over gnt/rvalid/ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_pc       <= RESET_VECTOR & c_word_mask;
            r_if_pc    <= 32'd0;
            r_if_instr <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (redirect)
                        r_pc <= w_redirect_pc;
                    r_state <= c_st_req;
                end
                c_st_req: begin
                    if (redirect) begin
                        r_pc    <= w_redirect_pc;
                        r_state <= imem_gnt ? c_st_drain : c_st_req;
                    end else if (imem_gnt) begin
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (redirect) begin
                        r_pc    <= w_redirect_pc;
                        r_state <= imem_rvalid ? c_st_req : c_st_drain;
                    end else if (imem_rvalid) begin
                        r_if_pc    <= r_pc;
                        r_if_instr <= imem_rdata;
                        r_state    <= c_st_full;
                    end
                end
                c_st_full: begin
                    if (redirect) begin
                        r_pc    <= w_redirect_pc;
                        r_state <= c_st_req;
                    end else if (if_ready) begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= c_st_req;
                    end
                end
                c_st_drain: begin
                    if (redirect)
                        r_pc <= w_redirect_pc;
                    if (imem_rvalid)
                        r_state <= c_st_req;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign imem_req  = (r_state == c_st_req);
    assign imem_addr = r_pc;
    assign if_valid  = (r_state == c_st_full);
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_fetch
//  Description : Self-checking bench for rv32i_fetch: directed scenarios and a
//                randomized memory/decoder against a PC-sequence model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_fetch;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    int n_pass  = 0;
    int n_total = 0;

    // Architectural model: the fetch PC plus the memory's single outstanding slot.
    logic [31:0] m_pc;
    logic [31:0] m_oaddr;
    bit          m_out;
    bit          m_live;
    int          m_cnt;
    bit          p_deliver, p_valid, p_rdy, p_redir, p_req, p_gnt;

    always #5 clk = ~clk;

    rv32i_fetch #(.RESET_VECTOR(RV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .next_pc     (next_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_ready    (if_ready)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        next_pc  = 32'd0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        if_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_pc = RV; m_oaddr = 32'd0; m_out = 0; m_live = 0; m_cnt = 0;
        p_deliver = 0; p_valid = 0; p_rdy = 0; p_redir = 0; p_req = 0; p_gnt = 0;
        chk("rst_req", imem_req, 32'd0);
        chk("rst_addr", imem_addr, RV);
        chk("rst_valid", if_valid, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
    endtask

    // One clock: memory answers, decode/redirect inputs applied, outputs checked
    // against the model, model advanced.
    task automatic cyc(input bit g, input bit rdy, input bit redir,
                       input logic [31:0] npc, input int lat);
        bit rv, grant, consume, deliver;
        rv    = m_out && (m_cnt == 0);
        grant = g && imem_req;
        imem_gnt    = grant;
        imem_rvalid = rv;
        imem_rdata  = rv ? memfn(m_oaddr) : $urandom;
        redirect    = redir;
        next_pc     = npc;
        if_ready    = rdy;

        chk("if_valid", if_valid, {31'd0, p_deliver || (p_valid && !p_rdy && !p_redir)});
        if (p_req && !p_gnt && !p_redir)
            chk("req_hold", imem_req, 32'd1);
        if (imem_req) begin
            chk("req_addr", imem_addr, m_pc);
            chk("one_outstanding", {31'd0, m_out}, 32'd0);
        end
        if (if_valid) begin
            chk("if_pc", if_pc, m_pc);
            chk("if_instr", if_instr, memfn(m_pc));
            chk("no_req_when_full", imem_req, 32'd0);
        end

        consume = if_valid && rdy && !redir;
        deliver = rv && m_live && !redir;
        if (redir)
            m_pc = npc & 32'hFFFF_FFFC;
        else if (consume)
            m_pc = m_pc + 32'd4;
        if (redir)
            m_live = 0;
        if (rv)
            m_out = 0;
        else if (m_out)
            m_cnt--;
        if (grant) begin
            m_out = 1; m_cnt = lat; m_live = !redir; m_oaddr = imem_addr;
        end
        p_deliver = deliver; p_valid = if_valid; p_rdy = rdy;
        p_redir = redir; p_req = imem_req; p_gnt = grant;
        @(posedge clk); #1;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++)
            cyc(($urandom % 3) != 0, ($urandom % 2) == 1, ($urandom % 8) == 0,
                $urandom, int'($urandom % 3));
    endtask

    initial begin
        do_reset();
        cyc(1, 1, 0, 32'd0, 0);

        // Streaming: one instruction every three cycles.
        for (int k = 0; k < 3; k++) begin
            chk("s_req", imem_req, 32'd1);
            chk("s_addr", imem_addr, 32'(4 * k));
            cyc(1, 1, 0, 32'd0, 0);
            chk("s_wait_req", imem_req, 32'd0);
            chk("s_wait_valid", if_valid, 32'd0);
            cyc(1, 1, 0, 32'd0, 0);
            chk("s_valid", if_valid, 32'd1);
            chk("s_if_pc", if_pc, 32'(4 * k));
            cyc(1, 1, 0, 32'd0, 0);
        end

        // Grant withheld for four cycles.
        for (int k = 0; k < 4; k++) begin
            chk("g_req", imem_req, 32'd1);
            chk("g_addr", imem_addr, 32'h0000_000C);
            cyc(0, 1, 0, 32'd0, 0);
        end
        cyc(1, 1, 0, 32'd0, 1);
        chk("g_wait", imem_req, 32'd0);
        cyc(0, 1, 0, 32'd0, 0);
        chk("g_wait2", if_valid, 32'd0);
        cyc(0, 1, 0, 32'd0, 0);

        // Decode stalls for five cycles.
        for (int k = 0; k < 5; k++) begin
            chk("st_valid", if_valid, 32'd1);
            chk("st_if_pc", if_pc, 32'h0000_000C);
            chk("st_instr", if_instr, memfn(32'h0000_000C));
            chk("st_req", imem_req, 32'd0);
            cyc(0, 0, 0, 32'd0, 0);
        end
        cyc(0, 1, 0, 32'd0, 0);

        // Redirect while waiting; stale response arrives two cycles later.
        chk("rw_addr", imem_addr, 32'h0000_0010);
        cyc(1, 0, 0, 32'd0, 2);
        cyc(0, 0, 1, 32'h0000_0100, 0);
        chk("rw_drain_req", imem_req, 32'd0);
        cyc(0, 0, 0, 32'd0, 0);
        chk("rw_drain_req2", imem_req, 32'd0);
        cyc(0, 0, 0, 32'd0, 0);
        chk("rw_valid", if_valid, 32'd0);
        chk("rw_req", imem_req, 32'd1);
        chk("rw_addr_new", imem_addr, 32'h0000_0100);
        cyc(1, 0, 0, 32'd0, 0);
        cyc(0, 0, 0, 32'd0, 0);
        chk("rw_instr", if_instr, memfn(32'h0000_0100));

        // Redirect with a simultaneous ready in FULL kills the instruction.
        cyc(0, 1, 1, 32'h0000_0203, 0);
        chk("rf_valid", if_valid, 32'd0);
        chk("rf_req", imem_req, 32'd1);
        chk("rf_addr", imem_addr, 32'h0000_0200);
        cyc(1, 0, 0, 32'd0, 0);
        cyc(0, 0, 0, 32'd0, 0);
        chk("rf_if_pc", if_pc, 32'h0000_0200);

        // PC wraps from the top word to zero.
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0);
        cyc(1, 0, 0, 32'd0, 0);
        cyc(0, 0, 0, 32'd0, 0);
        chk("wr_if_pc", if_pc, 32'hFFFF_FFFC);
        cyc(0, 1, 0, 32'd0, 0);
        chk("wr_req", imem_req, 32'd1);
        chk("wr_addr", imem_addr, 32'h0000_0000);

        rand_cycles(800);
        do_reset();
        rand_cycles(300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32i_fetch.md
# rv32i_fetch

Instruction-fetch front end of the RV32I core. Holds the architectural fetch PC and issues one word request at a time to instruction memory over a req/gnt/rvalid interface. It buffers the returned instruction for decode behind a valid/ready handshake. It is the consumer of the PC-select mux output: when the branch/JAL/JALR select logic redirects, this block loads the selected next PC, kills any younger fetch in flight, and refetches.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- redirect  in  1  taken branch / JAL / JALR resolved this cycle.
- next_pc  in  32  target from PC-select mux; sampled only when redirect=1.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word address of request (bits [1:0] always 0).
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  read data valid; exactly one per granted request, earliest the cycle after gnt.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  instruction buffer holds a live instruction.
- if_pc  out  32  PC of buffered instruction.
- if_instr  out  32  buffered instruction word.
- if_ready  in  1  decode consumes the buffer when if_valid & if_ready.

## Operation
- States: IDLE, REQ, WAIT, FULL, DRAIN. At most one request is outstanding.
- Reset (rst_n=0 at edge): state=IDLE, pc=RESET_VECTOR, if_valid=0, if_pc=0, if_instr=0. imem_req=0. imem_addr=pc.
- IDLE -> REQ unconditionally.
- REQ: imem_req=1, imem_addr=pc. On gnt go to WAIT. Otherwise stay, holding imem_addr stable.
- WAIT: imem_req=0. On rvalid, capture if_instr=rdata and if_pc=pc, set if_valid=1, go to FULL.
- FULL: if_valid=1. On if_ready, clear if_valid, set pc=pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0), go to REQ.
- DRAIN: imem_req=0. Waits for the one outstanding rvalid and discards it without touching the buffer, then goes to REQ.
- Redirect takes priority over every other event in the same cycle. In all cases pc = {next_pc[31:2], 2'b00} and if_valid=0 next cycle.
  - IDLE, FULL, or REQ without gnt: go to REQ. In FULL, a simultaneous if_ready is not a consume; the instruction is killed.
  - REQ with gnt, or WAIT without rvalid: the stale request is in flight; go to DRAIN.
  - WAIT with rvalid: drop rdata; go to REQ.
  - DRAIN: update pc. If rvalid arrives the same cycle go to REQ, otherwise stay in DRAIN.
- In REQ without gnt, imem_addr may change only because of a redirect.

## Timing
- All outputs are registered or decoded from state. No combinational path from input to output.
- Reset release at edge 0: IDLE in cycle 0, imem_req=1 in cycle 1.
- Best case per instruction, with gnt in REQ, rvalid the cycle after gnt, and if_ready=1: REQ, WAIT, FULL, giving one instruction per 3 cycles.
- if_valid rises the cycle after rvalid.
- Redirect to the new-target request: 1 cycle, or more while draining.
- rst_n low mid-operation: return to reset values on that edge. A memory response already in flight is the memory model's responsibility; the bench resets both.

## Test plan
- Reset, gnt=1 always, rvalid 1 cycle after gnt, if_ready=1 -> imem_addr sequence 0x0,0x4,0x8; if_pc matches; if_valid pulses every 3rd cycle.
- gnt held low 4 cycles in REQ -> imem_req=1 and imem_addr constant all 4 cycles; WAIT entered only after gnt.
- FULL with if_ready=0 for 5 cycles -> if_valid, if_pc, if_instr stable; no new imem_req.
- redirect=1, next_pc=0x100 in WAIT (rvalid 2 cycles later) -> DRAIN; stale rdata never appears on if_instr; next imem_addr=0x100.
- redirect=1, next_pc=0x203, with if_ready=1 in FULL -> if_valid=0 next cycle; imem_addr=0x200; the killed instruction is never consumed.
- pc=0xFFFF_FFFC consumed -> next imem_addr=0x0000_0000.
